// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Optional even-parity framing is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [2:0] TXDATA_OFS = 3'h0;
  localparam logic [2:0] STATUS_OFS = 3'h4;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  function automatic logic even_par(
    input logic [7:0] b
  );
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide circular TX FIFO with wrapping pointers and an occupancy count.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [7:0]             din_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [7:0]             dout_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) wptr_d = wptr_q + PTR_ONE;
    if (pop_i)  rptr_d = rptr_q + PTR_ONE;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= din_i;
  end

  assign full_o  = (cnt_q == CNT_MAX);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rptr_q];

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: store-bus decode, TX FIFO and 8N1 shift FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLK_HZ     = 100_000_000,
  parameter int          BAUD       = 115200,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        rd_sel,
  output logic        tx,
  output logic        busy
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int CW   = $clog2(DIV);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  tx_state_t state_q, state_d;

  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            ovf_q, ovf_d;
  logic            tick;
  logic            pop;
  logic            push;
  logic            drop;
  logic            wr, wr_data, wr_stat;
  logic            full, empty;
  logic [CNTW-1:0] fifo_cnt;
  logic [7:0]      fifo_dout;
  logic            unused_bits;

  assign rd_sel  = (addr[31:3] == BASE_ADDR[31:3]);
  assign wr      = rd_sel && (memwrite != 2'b00);
  assign wr_data = wr && (addr[2] == TXDATA_OFS[2]);
  assign wr_stat = wr && (addr[2] == STATUS_OFS[2]);

  // A pop in the same edge frees the slot, so a full FIFO still accepts.
  assign push = wr_data && (!full || pop);
  assign drop = wr_data && full && !pop;

  assign unused_bits = ^{addr[1:0], wd[31:8], fifo_cnt};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (wd[7:0]),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_cnt),
    .dout_o  (fifo_dout)
  );

  assign ovf_d = drop |
                 (ovf_q & ~(wr_stat & wd[ST_OVF]));

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign busy = (state_q != IDLE) || !empty;

  always_comb begin
    rd = '0;
    if (rd_sel && (addr[2] == STATUS_OFS[2])) begin
      rd[ST_FULL]  = full;
      rd[ST_EMPTY] = empty;
      rd[ST_BUSY]  = busy;
      rd[ST_OVF]   = ovf_q;
    end
  end

  assign tick = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick && bitcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every state entry happens on a tick or from IDLE, so this also
  // restarts the baud count on each state change.
  always_comb begin
    baud_d   = baud_q + BAUD_ONE;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    if (state_q == IDLE || tick) baud_d = '0;
    if (state_q != DATA) begin
      bitcnt_d = '0;
    end else if (tick) begin
      bitcnt_d = bitcnt_q + 3'd1;
      shreg_d  = {1'b0, shreg_q[7:1]};
    end
    if (pop) shreg_d = fifo_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q   <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
    end else begin
      baud_q   <= baud_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;

  assign par_d = pop ? even_par(fifo_dout) : par_q;

  always_ff @(posedge clk) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_d;
  end
`endif

  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      START:  tx = 1'b0;
      DATA:   tx = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx = par_q;
`endif
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio at DIV=8.
// Frame-length and parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx_mmio;

  localparam int DIV = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  memwrite = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        rd_sel;
  logic        tx;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_mmio #(
    .CLK_HZ     (8_000_000),
    .BAUD       (1_000_000),
    .BASE_ADDR  (32'h1000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .addr     (addr),
    .wd       (wd),
    .rd       (rd),
    .rd_sel   (rd_sel),
    .tx       (tx),
    .busy     (busy)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Line receiver: samples each bit mid-cell from the first low cycle.
  logic       mon_en = 1'b0;
  logic [7:0] rx_b[$];
  int         rx_t[$];
  logic       rx_p[$];
  logic       rx_s[$];
  logic [7:0] m_b;
  int         m_t;
  logic       m_p;
  logic       m_s;

  initial forever begin
    @(negedge clk);
    if (mon_en && !reset && tx === 1'b0) begin
      m_t = cyc;
      m_b = '0;
      m_p = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (8) @(negedge clk);
        m_b[i] = tx;
      end
`ifdef UART_TX_PARITY_EN
      repeat (8) @(negedge clk);
      m_p = tx;
`endif
      repeat (8) @(negedge clk);
      m_s = tx;
      rx_b.push_back(m_b);
      rx_t.push_back(m_t);
      rx_p.push_back(m_p);
      rx_s.push_back(m_s);
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] exp_bits;
    logic [7:0]    exp_b [6];
    int            bud;
    int            lows;
    int            t_low;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    addr = 32'h1004;
    #1 chk("rst_status", rd, 32'h2);
    chk("rst_rdsel", rd_sel, 1);
    addr = 32'h2004;
    #1 chk("nosel_rdsel", rd_sel, 0);
    chk("nosel_rd", rd, 0);
    addr = 32'h1000;
    #1 chk("txdata_rd", rd, 0);
    mon_en = 1'b1;

    // single byte A5
    @(negedge clk);
    memwrite = 2'b01;
    addr = 32'h1000;
    wd = 32'hA5;
    @(negedge clk);
    memwrite = 2'b00;
    chk("a5_pushed_tx", tx, 1);
    chk("a5_pushed_busy", busy, 1);
    addr = 32'h1004;
    #1 chk("a5_status", rd, 32'h4);
    @(negedge clk);
    chk("a5_fall", tx, 0);
`ifdef UART_TX_PARITY_EN
    exp_bits = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
    exp_bits = {1'b1, 8'hA5, 1'b0};
`endif
    for (int k = 0; k < NB; k++) begin
      if (k == 0) repeat (4) @(negedge clk);
      else        repeat (8) @(negedge clk);
      chk($sformatf("a5_bit%0d", k), tx, exp_bits[k]);
    end
    repeat (3) @(negedge clk);
    chk("a5_busy_last", busy, 1);
    @(negedge clk);
    chk("a5_busy_drop", busy, 0);
    chk("a5_idle_tx", tx, 1);
    rx_b.delete();
    rx_t.delete();
    rx_p.delete();
    rx_s.delete();

    // six back-to-back writes, last one overflows
    @(negedge clk);
    memwrite = 2'b01;
    addr = 32'h1000;
    wd = 32'h1;
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      wd = i;
    end
    @(negedge clk);
    memwrite = 2'b00;
    addr = 32'h1004;
    #1 chk("ovf_set", rd, 32'hD);
    memwrite = 2'b11;
    wd = 32'h8;
    @(negedge clk);
    memwrite = 2'b00;
    #1 chk("ovf_clr", rd, 32'h5);
    // land a push on the edge where STOP of byte 01 pops
    repeat (FRAME - 6) @(negedge clk);
    #1 chk("full_pre", rd, 32'h5);
    memwrite = 2'b01;
    addr = 32'h1000;
    wd = 32'h77;
    @(negedge clk);
    memwrite = 2'b00;
    addr = 32'h1004;
    #1 chk("push_on_pop", rd, 32'h5);

    bud = 0;
    while (rx_b.size() < 6 && bud < 8 * FRAME) begin
      @(negedge clk);
      bud++;
    end
    chk("b2b_count", rx_b.size(), 6);
    exp_b[0] = 8'h01;
    exp_b[1] = 8'h02;
    exp_b[2] = 8'h03;
    exp_b[3] = 8'h04;
    exp_b[4] = 8'h05;
    exp_b[5] = 8'h77;
    for (int i = 0; i < 6; i++) begin
      if (i < rx_b.size()) begin
        chk($sformatf("b2b_byte%0d", i), rx_b[i], exp_b[i]);
        chk($sformatf("b2b_stop%0d", i), rx_s[i], 1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (i + 1 < rx_t.size())
        chk($sformatf("b2b_gap%0d", i), rx_t[i+1] - rx_t[i], FRAME);
    end
    bud = 0;
    while (busy && bud < 4 * FRAME) begin
      @(negedge clk);
      bud++;
    end
    chk("b2b_drain", busy, 0);
    repeat (2 * FRAME) @(negedge clk);
    chk("b2b_no06", rx_b.size(), 6);

    // reset during data bit 3
    mon_en = 1'b0;
    @(negedge clk);
    memwrite = 2'b01;
    addr = 32'h1000;
    wd = 32'h3C;
    @(negedge clk);
    wd = 32'h11;
    @(negedge clk);
    wd = 32'h22;
    @(negedge clk);
    memwrite = 2'b00;
    repeat (34) @(negedge clk);
    chk("r_bit3", tx, 1);
    chk("r_busy_pre", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("r_tx", tx, 1);
    chk("r_busy", busy, 0);
    addr = 32'h1004;
    #1 chk("r_status", rd, 32'h2);
    reset = 1'b0;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("r_quiet", lows, 0);

    // single byte 07: frame length and parity
    rx_b.delete();
    rx_t.delete();
    rx_p.delete();
    rx_s.delete();
    mon_en = 1'b1;
    @(negedge clk);
    memwrite = 2'b01;
    addr = 32'h1000;
    wd = 32'h07;
    @(negedge clk);
    memwrite = 2'b00;
    bud = 0;
    while (rx_b.size() < 1 && bud < 2 * FRAME) begin
      @(negedge clk);
      bud++;
    end
    chk("p07_count", rx_b.size(), 1);
    bud = 0;
    while (busy && bud < 2 * FRAME) begin
      @(negedge clk);
      bud++;
    end
    t_low = cyc;
    if (rx_b.size() > 0) begin
      chk("p07_byte", rx_b[0], 8'h07);
      chk("p07_len", t_low - rx_t[0], FRAME);
`ifdef UART_TX_PARITY_EN
      chk("p07_par", rx_p[0], 1);
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
